// File: rtl/seg7_multi_display.sv
// Multi-digit seven-segment driver: serial binary-to-BCD (shift-add-3), leading-zero
// blanking, sign, overflow and halt override. All outputs come straight from flops.
module seg7_multi_display #(
  parameter int DIGITS = 4,
  parameter int WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      value,
  input  logic                  is_signed,
  input  logic                  load,
  input  logic                  halt,
  output logic [7*DIGITS-1:0]   seg,
  output logic                  busy,
  output logic                  overflow
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH);
  localparam logic [6:0] GLYPH_H     = 7'b0001001;
  localparam logic [6:0] GLYPH_MINUS = 7'b0111111;
  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

  typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_t;

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      mag_q, mag_d;
  logic [BW-1:0]         bcd_q, bcd_d;
  logic                  carry_q, carry_d;
  logic                  neg_q, neg_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [7*DIGITS-1:0]   image_q, image_d;
  logic                  ovf_q, ovf_d;
  logic                  busy_q, busy_d;
  logic                  halt_q, halt_d;

  logic [BW-1:0]         bcd_adj;
  logic [7*DIGITS-1:0]   image_calc;
  logic                  ovf_calc;
  int                    msd;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 7'b1000000;
      4'd1:    glyph = 7'b1111001;
      4'd2:    glyph = 7'b0100100;
      4'd3:    glyph = 7'b0110000;
      4'd4:    glyph = 7'b0011001;
      4'd5:    glyph = 7'b0010010;
      4'd6:    glyph = 7'b0000010;
      4'd7:    glyph = 7'b1111000;
      4'd8:    glyph = 7'b0000000;
      4'd9:    glyph = 7'b0011000;
      default: glyph = GLYPH_BLANK;
    endcase
  endfunction

  // Add-3 correction of the accumulator and the display image built from it
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    msd = 0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] != 4'd0) msd = i;
    end
    ovf_calc   = carry_q || (neg_q && (msd == DIGITS - 1));
    image_calc = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (ovf_calc)                      image_calc[7*i +: 7] = GLYPH_MINUS;
      else if (i <= msd)                 image_calc[7*i +: 7] = glyph(bcd_q[4*i +: 4]);
      else if (neg_q && (i == msd + 1))  image_calc[7*i +: 7] = GLYPH_MINUS;
      else                               image_calc[7*i +: 7] = GLYPH_BLANK;
    end
  end

  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    bcd_d   = bcd_q;
    carry_d = carry_q;
    neg_d   = neg_q;
    cnt_d   = cnt_q;
    image_d = image_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    halt_d  = halt;
    case (state_q)
      IDLE: begin
        if (load) begin
          neg_d   = is_signed && value[WIDTH-1];
          mag_d   = (is_signed && value[WIDTH-1]) ? (~value + WIDTH'(1)) : value;
          bcd_d   = '0;
          carry_d = 1'b0;
          cnt_d   = CW'(WIDTH - 1);
          busy_d  = 1'b1;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        // Anything leaving the top nibble means the value needs more digits
        carry_d = carry_q | bcd_adj[BW-1];
        bcd_d   = {bcd_adj[BW-2:0], mag_q[WIDTH-1]};
        mag_d   = {mag_q[WIDTH-2:0], 1'b0};
        if (cnt_q == '0) state_d = UPDATE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      UPDATE: begin
        image_d = image_calc;
        ovf_d   = ovf_calc;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mag_q   <= '0;
      bcd_q   <= '0;
      carry_q <= 1'b0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      image_q <= '1;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      bcd_q   <= bcd_d;
      carry_q <= carry_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
      image_q <= image_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      halt_q  <= halt_d;
    end
  end

  assign seg      = halt_q ? {DIGITS{GLYPH_H}} : image_q;
  assign busy     = busy_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_seg7_multi_display.sv
// Scoreboard bench for seg7_multi_display (DIGITS=4, WIDTH=16): expected images
// come from a decimal-division reference model queued at load time.
module tb_seg7_multi_display;

  localparam logic [6:0]  G_MINUS = 7'b0111111;
  localparam logic [6:0]  G_BLANK = 7'b1111111;
  localparam logic [27:0] ALL_H   = {4{7'b0001001}};
  localparam logic [27:0] ALL_BLK = 28'hFFFFFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = '0;
  logic        is_signed = 1'b0;
  logic        load = 1'b0;
  logic        halt = 1'b0;
  logic [27:0] seg;
  logic        busy;
  logic        overflow;

  int n_pass = 0;
  int n_chk  = 0;
  logic [28:0] sb[$];
  logic [28:0] exp_v;

  seg7_multi_display #(.DIGITS(4), .WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .is_signed(is_signed),
    .load(load), .halt(halt), .seg(seg), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, want);
  endtask

  function automatic logic [6:0] g7(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0011000;
      default: return G_BLANK;
    endcase
  endfunction

  // Returns {overflow, seg}
  function automatic logic [28:0] model(input logic [15:0] v, input logic s);
    int mag, tmp, m;
    int d[4];
    logic neg, ovf;
    logic [27:0] sg;
    neg = s & v[15];
    mag = neg ? (65536 - int'(v)) : int'(v);
    tmp = mag;
    m = 0;
    for (int i = 0; i < 4; i++) begin
      d[i] = tmp % 10;
      tmp  = tmp / 10;
      if (d[i] != 0) m = i;
    end
    ovf = (mag > 9999) || (neg && m == 3);
    for (int i = 0; i < 4; i++) begin
      if (ovf)                     sg[7*i +: 7] = G_MINUS;
      else if (i <= m)             sg[7*i +: 7] = g7(d[i]);
      else if (neg && i == m + 1)  sg[7*i +: 7] = G_MINUS;
      else                         sg[7*i +: 7] = G_BLANK;
    end
    return {ovf, sg};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic [15:0] v, input logic s);
    value = v;
    is_signed = s;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  // Returns number of cycles busy stayed high after the load edge (bounded)
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic do_load(input string tag, input logic [15:0] v, input logic s);
    int n;
    sb.push_back(model(v, s));
    start_load(v, s);
    wait_idle(n);
    chk({tag, "_busy_len"}, n, 17);
    exp_v = sb.pop_front();
    chk({tag, "_seg"}, seg, exp_v[27:0]);
    chk({tag, "_ovf"}, overflow, exp_v[28]);
  endtask

  initial begin
    int n;
    value = 16'h1234;
    #12;
    chk("rst_async_seg", seg, ALL_BLK);
    rst_n = 1'b1;
    repeat (40) tick();
    chk("idle_seg", seg, ALL_BLK);
    chk("idle_busy", busy, 0);
    chk("idle_ovf", overflow, 0);

    do_load("u1234", 16'd1234, 1'b0);
    do_load("u0", 16'd0, 1'b0);
    do_load("s_m7", 16'hFFF9, 1'b1);
    do_load("s_m1000", 16'hFC18, 1'b1);
    do_load("u999", 16'd999, 1'b0);
    do_load("s_m999", 16'hFC19, 1'b1);
    do_load("u10000", 16'd10000, 1'b0);
    do_load("u65535", 16'd65535, 1'b0);
    do_load("u42", 16'd42, 1'b0);
    do_load("s_min", 16'h8000, 1'b1);
    do_load("s_pos", 16'd305, 1'b1);
    do_load("u_neg_bits", 16'hFFF9, 1'b0);

    // Halt during a conversion, load while busy must be dropped
    sb.push_back(model(16'd77, 1'b0));
    start_load(16'd77, 1'b0);
    repeat (4) tick();
    halt = 1'b1;
    tick();
    chk("halt_seg", seg, ALL_H);
    value = 16'd88;
    load = 1'b1;
    tick();
    load = 1'b0;
    chk("halt_busy", busy, 1);
    wait_idle(n);
    chk("halt_done", n < 40, 1);
    exp_v = sb.pop_front();
    chk("halt_hold_seg", seg, ALL_H);
    chk("halt_ovf", overflow, exp_v[28]);
    halt = 1'b0;
    tick();
    chk("unhalt_seg", seg, exp_v[27:0]);
    repeat (20) tick();
    chk("no_queue_busy", busy, 0);
    chk("no_queue_seg", seg, exp_v[27:0]);

    // Async reset in the middle of a conversion
    start_load(16'd1234, 1'b0);
    repeat (7) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_seg", seg, ALL_BLK);
    chk("midrst_busy", busy, 0);
    chk("midrst_ovf", overflow, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (25) tick();
    chk("post_rst_seg", seg, ALL_BLK);
    chk("post_rst_busy", busy, 0);
    do_load("post_rst_u5", 16'd5, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/seg7_multi_display.md
# seg7_multi_display

Parametrised multi-digit seven-segment display driver for the processor's board I/O. It accepts a binary value with a one-cycle load strobe and converts it serially to BCD (shift-add-3, one bit per cycle). It then drives DIGITS active-low seven-segment outputs with leading-zero blanking, a minus sign for signed values, an overflow indication and a halt override. The display stays blank from reset until the first conversion completes.

## Interface
- DIGITS, 4, number of seven-segment digits driven (≥2)
- WIDTH, 16, width of the binary input value (≥4)
- Clock  input  1  system clock, rising-edge active
- Reset  input  1  asynchronous, active-low reset
- value  input  WIDTH  binary value to display
- is_signed  input  1  value is two's complement; sampled with load
- load  input  1  one-cycle strobe: capture value and start conversion
- halt  input  1  level; while registered high, every digit shows "H"
- seg  output  7*DIGITS  segments, digit 0 (rightmost) at seg[6:0], bit order gfedcba, active-low
- busy  output  1  conversion in progress
- overflow  output  1  last conversion did not fit in DIGITS positions

## Operation
- Glyphs (gfedcba, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000
  - H=0001001, minus=0111111, blank=1111111
- FSM states: IDLE, CONVERT, UPDATE.
- IDLE: on load=1, capture the magnitude and the sign, clear the BCD accumulator (4*DIGITS bits) and a sticky carry flag, then go to CONVERT.
- Magnitude and sign: if is_signed=1 and value[WIDTH-1]=1, magnitude = (~value+1) as WIDTH-bit unsigned and neg=1. Otherwise magnitude = value and neg=0. For the most-negative value, magnitude is 2^(WIDTH-1); this is correct as unsigned.
- CONVERT: runs exactly WIDTH cycles. Each cycle:
  - add 3 to every BCD nibble ≥5;
  - shift {bcd, magnitude} left by 1;
  - any bit shifted out of the top nibble sets the sticky carry flag.
  - Exits to UPDATE after the WIDTH-th shift.
- UPDATE: one cycle, registers the display image, then returns to IDLE.
  - Let m = index of the most significant nonzero digit; m=0 when the value is 0.
  - Overflow when any of these holds: the carry flag is set; a nonzero digit exists at an index ≥ DIGITS; or neg=1 and m = DIGITS-1.
  - Overflow: all digits show minus, overflow=1.
  - Otherwise: digits 0..m show their BCD glyph. If neg=1, digit m+1 shows minus. All higher digits are blank. overflow=0.
- load while busy=1 is ignored; no queueing.
- Display register output: seg = halt_q ? all H : image. halt_q is halt registered once.
- halt does not stall or alter conversion. Halt beats overflow.
- BCD codes 10–15 never occur internally. The decoder maps them to blank.

## Timing
- Reset (asynchronous, Reset=0):
  - seg = all 1s (blank), busy=0, overflow=0;
  - FSM to IDLE; halt_q=0; image = blank.
  - Takes effect immediately, including mid-conversion; any in-flight conversion is discarded.
- Reset release: blank persists, regardless of value, until the first UPDATE.
- Load latency: load sampled at edge k.
  - busy=1 after edge k through edge k+WIDTH+1 (WIDTH+1 cycles high).
  - seg and overflow update at edge k+WIDTH+1.
  - Earliest accepted next load: sampled at edge k+WIDTH+2.
- halt → seg latency: 1 cycle in both directions. The image is preserved underneath.
- Outputs are all registered. No combinational path from inputs to seg, busy or overflow.

## Test plan
- Reset, then 40 cycles with load=0 and value=16'h1234 → seg=28'hFFFFFFF, busy=0, overflow=0.
- DIGITS=4, WIDTH=16: load value=1234 unsigned → busy high exactly 17 cycles; then seg digits[3:0] = 1,2,3,4 glyphs, overflow=0. Load 0 → blank,blank,blank,"0".
- Signed: value=16'hFFF9 (-7) → blank,blank,minus,"7". 16'hFC18 (-1000) → overflow=1, all minus. Unsigned 999 → blank,9,9,9. Signed -999 → minus,9,9,9.
- Unsigned 10000 and 65535 → overflow=1, all digits minus. A following load of 42 → blank,blank,4,2, overflow=0.
- Halt and busy interaction:
  - Raise halt 5 cycles into a conversion of 77 → seg = all 0001001 one cycle later.
  - A load pulse of 88 while busy is ignored.
  - Drop halt after completion → seg shows blank,blank,7,7 one cycle later.
- Assert Reset mid-conversion (cycle 8) → seg blank and busy=0 immediately, without waiting for a clock edge. After release, the display stays blank until a new load completes.
